// File: rtl/setup_ctrl_n_if.sv
// Keypad digit-collector handshake into the setup controller: a complete
// digit vector qualified by a one-cycle valid strobe.
interface setup_ctrl_n_if #(
  parameter int MAX_DIGITS = 20
);
  logic [4*MAX_DIGITS-1:0] digitos_value;
  logic                    digitos_valid;

  modport master (output digitos_value, output digitos_valid);
  modport slave  (input  digitos_value, input  digitos_valid);
endinterface

// File: rtl/setup_ctrl_n.sv
// Setup controller for the electronic lock: edits a shadow configuration and
// commits it atomically. Optional inactivity abort: define SETUP_TIMEOUT_EN.
module setup_ctrl_n #(
  parameter int NUM_USERS     = 4,
  parameter int MAX_DIGITS    = 20,
  parameter int PW_MIN_DIGITS = 4,
  parameter int TIME_MIN      = 5,
  parameter int TIME_MAX      = 60,
  parameter int TIME_DEF      = 5,
  parameter int MAX_TRIES     = 3,
  parameter int TIMEOUT_CYC   = 500000000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              setup_on,
  setup_ctrl_n_if.slave                     key,
  output logic                              display_en,
  output logic [23:0]                       bcd_pac,
  output logic                              cfg_bip_status,
  output logic [5:0]                        cfg_bip_time,
  output logic [5:0]                        cfg_trc_time,
  output logic [4*MAX_DIGITS-1:0]           cfg_senha_master,
  output logic [NUM_USERS*4*MAX_DIGITS-1:0] cfg_senha_users,
  output logic                              data_setup_ok,
  output logic                              setup_abort,
  output logic                              entry_err
);

  localparam int PW_W   = 4 * MAX_DIGITS;
  localparam int USR_W  = NUM_USERS * PW_W;
  localparam int UIDX_W = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);

  localparam logic [UIDX_W-1:0] UIDX_LAST = UIDX_W'(NUM_USERS - 1);
  localparam logic [TRY_W-1:0]  TRY_LIM   = TRY_W'(MAX_TRIES);
  localparam logic [6:0]        TMIN7     = 7'(TIME_MIN);
  localparam logic [6:0]        TMAX7     = 7'(TIME_MAX);
  localparam logic [5:0]        TDEF6     = 6'(TIME_DEF);
  localparam logic [PW_W-1:0]   MASTER_RST = {{(PW_W-16){1'b1}}, 16'h1234};

  typedef enum logic [3:0] {
    S_IDLE, S_AUTH, S_BIP, S_TBIP, S_TTRC, S_MASTER, S_USER, S_SAVE, S_ABORT
  } state_t;

  state_t             state, state_nxt;
  logic [UIDX_W-1:0]  user_idx, user_nxt;
  logic [TRY_W-1:0]   tries, tries_nxt;
  logic               armed, armed_nxt;
  logic               sh_bip, sh_bip_nxt;
  logic [5:0]         sh_tbip, sh_tbip_nxt, sh_ttrc, sh_ttrc_nxt;
  logic [PW_W-1:0]    sh_master, sh_master_nxt;
  logic [USR_W-1:0]   sh_users, sh_users_nxt;
  logic               err_nxt, ok_nxt, abort_nxt, commit;
  logic               timeout;

  logic [PW_W-1:0]    key_val;
  logic               key_vld, skip, pw_good;
  logic [6:0]         tchk;

  // An all-empty vector is the "keep this field" entry.
  function automatic logic is_empty(input logic [PW_W-1:0] v);
    return v == {PW_W{1'b1}};
  endfunction

  // Accept only a contiguous run of digits from digit 0, long enough.
  function automatic logic pw_valid(input logic [PW_W-1:0] v);
    int   cnt;
    logic gap, bad;
    cnt = 0;
    gap = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (v[4*i +: 4] == 4'hF) gap = 1'b1;
      else if (gap)            bad = 1'b1;
      else                     cnt++;
    end
    return !bad && (cnt >= PW_MIN_DIGITS);
  endfunction

  // Returns {reject, seconds}; range check on the 7-bit value before truncation.
  function automatic logic [6:0] time_chk(input logic [PW_W-1:0] v);
    logic [3:0] d0, d1;
    logic [6:0] val;
    logic       bad;
    d0  = v[3:0];
    d1  = v[7:4];
    bad = (d0 > 4'd9) || ((d1 > 4'd9) && (d1 != 4'hF));
    val = (d1 == 4'hF) ? {3'b000, d0} : (7'(d1) * 7'd10 + 7'(d0));
    if (!bad && (val >= TMIN7) && (val <= TMAX7)) return {1'b0, val[5:0]};
    return {1'b1, TDEF6};
  endfunction

  function automatic logic [7:0] to_bcd2(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  assign key_val = key.digitos_value;
  assign key_vld = key.digitos_valid;
  assign skip    = is_empty(key_val);
  assign pw_good = pw_valid(key_val);
  assign tchk    = time_chk(key_val);

`ifdef SETUP_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (!rst || state == S_IDLE || key_vld) idle_cnt <= '0;
    else if (idle_cnt != CNT_LAST)          idle_cnt <= idle_cnt + 1'b1;
  end
  assign timeout = (idle_cnt == CNT_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    user_nxt      = user_idx;
    tries_nxt     = tries;
    armed_nxt     = armed | ~setup_on;
    sh_bip_nxt    = sh_bip;
    sh_tbip_nxt   = sh_tbip;
    sh_ttrc_nxt   = sh_ttrc;
    sh_master_nxt = sh_master;
    sh_users_nxt  = sh_users;
    err_nxt       = 1'b0;
    ok_nxt        = 1'b0;
    abort_nxt     = 1'b0;
    commit        = 1'b0;
    case (state)
      S_IDLE: begin
        if (setup_on && armed) begin
          state_nxt     = S_AUTH;
          tries_nxt     = '0;
          user_nxt      = '0;
          sh_bip_nxt    = cfg_bip_status;
          sh_tbip_nxt   = cfg_bip_time;
          sh_ttrc_nxt   = cfg_trc_time;
          sh_master_nxt = cfg_senha_master;
          sh_users_nxt  = cfg_senha_users;
        end
      end
      S_SAVE: begin
        commit    = 1'b1;
        ok_nxt    = 1'b1;
        state_nxt = S_IDLE;
        armed_nxt = ~setup_on;
      end
      S_ABORT: begin
        abort_nxt = 1'b1;
        state_nxt = S_IDLE;
        armed_nxt = ~setup_on;
      end
      default: begin
        // Losing setup_on wins over a key strobe in the same cycle.
        if (!setup_on) begin
          state_nxt = S_ABORT;
        end else if (key_vld) begin
          case (state)
            S_AUTH: begin
              if (key_val == cfg_senha_master) begin
                state_nxt = S_BIP;
              end else begin
                tries_nxt = tries + 1'b1;
                err_nxt   = 1'b1;
                if (tries_nxt == TRY_LIM) state_nxt = S_ABORT;
              end
            end
            S_BIP: begin
              if (skip) begin
                state_nxt = S_TBIP;
              end else if (key_val[3:1] == 3'b000) begin
                sh_bip_nxt = key_val[0];
                state_nxt  = S_TBIP;
              end else begin
                err_nxt = 1'b1;
              end
            end
            S_TBIP: begin
              state_nxt = S_TTRC;
              if (!skip) begin
                sh_tbip_nxt = tchk[5:0];
                err_nxt     = tchk[6];
              end
            end
            S_TTRC: begin
              state_nxt = S_MASTER;
              if (!skip) begin
                sh_ttrc_nxt = tchk[5:0];
                err_nxt     = tchk[6];
              end
            end
            S_MASTER: begin
              if (skip || pw_good) begin
                if (!skip) sh_master_nxt = key_val;
                state_nxt = S_USER;
                user_nxt  = '0;
              end else begin
                err_nxt = 1'b1;
              end
            end
            S_USER: begin
              if (skip || pw_good) begin
                if (!skip) sh_users_nxt[int'(user_idx)*PW_W +: PW_W] = key_val;
                if (user_idx == UIDX_LAST) state_nxt = S_SAVE;
                else                       user_nxt  = user_idx + 1'b1;
              end else begin
                err_nxt = 1'b1;
              end
            end
            default: ;
          endcase
        end else if (timeout) begin
          state_nxt = S_ABORT;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= S_IDLE;
      user_idx         <= '0;
      tries            <= '0;
      armed            <= 1'b1;
      sh_bip           <= 1'b1;
      sh_tbip          <= 6'd5;
      sh_ttrc          <= 6'd5;
      sh_master        <= MASTER_RST;
      sh_users         <= '1;
      cfg_bip_status   <= 1'b1;
      cfg_bip_time     <= 6'd5;
      cfg_trc_time     <= 6'd5;
      cfg_senha_master <= MASTER_RST;
      cfg_senha_users  <= '1;
      data_setup_ok    <= 1'b0;
      setup_abort      <= 1'b0;
      entry_err        <= 1'b0;
    end else begin
      state         <= state_nxt;
      user_idx      <= user_nxt;
      tries         <= tries_nxt;
      armed         <= armed_nxt;
      sh_bip        <= sh_bip_nxt;
      sh_tbip       <= sh_tbip_nxt;
      sh_ttrc       <= sh_ttrc_nxt;
      sh_master     <= sh_master_nxt;
      sh_users      <= sh_users_nxt;
      data_setup_ok <= ok_nxt;
      setup_abort   <= abort_nxt;
      entry_err     <= err_nxt;
      if (commit) begin
        cfg_bip_status   <= sh_bip;
        cfg_bip_time     <= sh_tbip;
        cfg_trc_time     <= sh_ttrc;
        cfg_senha_master <= sh_master;
        cfg_senha_users  <= sh_users;
      end
    end
  end

  assign display_en = (state != S_IDLE);

  // BCD5 names the field; BCD1/BCD0 echo the shadow value of bip/time fields.
  always_comb begin
    bcd_pac = '1;
    case (state)
      S_AUTH, S_BIP: bcd_pac[23:20] = 4'd1;
      S_TBIP:        bcd_pac[23:20] = 4'd2;
      S_TTRC:        bcd_pac[23:20] = 4'd3;
      S_MASTER:      bcd_pac[23:20] = 4'd4;
      S_USER:        bcd_pac[23:20] = 4'd5 + 4'(user_idx);
      default: ;
    endcase
    case (state)
      S_BIP:  bcd_pac[7:0] = {7'd0, sh_bip};
      S_TBIP: bcd_pac[7:0] = to_bcd2(sh_tbip);
      S_TTRC: bcd_pac[7:0] = to_bcd2(sh_ttrc);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_setup_ctrl_n.sv
// Scoreboard bench for setup_ctrl_n: a field-level session model predicts every
// pulse and the committed configuration; a monitor checks each pulse as it appears.
module tb_setup_ctrl_n;
  localparam int NU    = 4;
  localparam int MD    = 20;
  localparam int PW_W  = 4 * MD;
  localparam int USR_W = NU * PW_W;
  localparam int K_OK = 1, K_ABORT = 2, K_ERR = 4;

  logic clk = 1'b0;
  logic rst, setup_on;
  logic display_en, cfg_bip_status, data_setup_ok, setup_abort, entry_err;
  logic [23:0] bcd_pac;
  logic [5:0] cfg_bip_time, cfg_trc_time;
  logic [PW_W-1:0] cfg_senha_master;
  logic [USR_W-1:0] cfg_senha_users;

  always #5 clk = ~clk;

  setup_ctrl_n_if #(.MAX_DIGITS(MD)) key();

  setup_ctrl_n #(.NUM_USERS(NU), .MAX_DIGITS(MD), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .setup_on(setup_on), .key(key),
    .display_en(display_en), .bcd_pac(bcd_pac),
    .cfg_bip_status(cfg_bip_status), .cfg_bip_time(cfg_bip_time),
    .cfg_trc_time(cfg_trc_time), .cfg_senha_master(cfg_senha_master),
    .cfg_senha_users(cfg_senha_users), .data_setup_ok(data_setup_ok),
    .setup_abort(setup_abort), .entry_err(entry_err)
  );

  typedef struct {
    int               kind;
    logic             bip;
    logic [5:0]       tb;
    logic [5:0]       tt;
    logic [PW_W-1:0]  m;
    logic [USR_W-1:0] u;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;

  // Model: committed (c_) and shadow (s_) config, current field 0=auth,1..4,5+k users
  logic             c_bip, s_bip;
  logic [5:0]       c_tb, c_tt, s_tb, s_tt;
  logic [PW_W-1:0]  c_m, s_m;
  logic [USR_W-1:0] c_u, s_u;
  int               fld, tries;
  bit               active;

  task automatic chk(input string name, input logic [USR_W-1:0] act, input logic [USR_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW_W-1:0] pw(input logic [31:0] h, input int n);
    logic [PW_W-1:0] v;
    v = '1;
    for (int i = 0; i < n; i++) v[4*i +: 4] = h[4*i +: 4];
    return v;
  endfunction

  function automatic logic [PW_W-1:0] mk_pw(input int n, input bit gap);
    logic [PW_W-1:0] v;
    v = '1;
    for (int i = 0; i < n; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if (gap) v[4*(n + 1 + $urandom_range(0, 3)) +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  function automatic bit m_pw_ok(input logic [PW_W-1:0] v);
    int n;
    n = 0;
    while (n < MD && v[4*n +: 4] != 4'hF) n++;
    for (int i = n; i < MD; i++) if (v[4*i +: 4] != 4'hF) return 1'b0;
    return n >= 4;
  endfunction

  task automatic m_time(input logic [PW_W-1:0] v, output logic [5:0] r, output bit e);
    int d1, d0, val;
    d0  = int'(v[3:0]);
    d1  = int'(v[7:4]);
    val = (d1 == 15) ? d0 : d1 * 10 + d0;
    e   = (d0 > 9) || (d1 > 9 && d1 != 15) || val < 5 || val > 60;
    r   = e ? 6'd5 : 6'(val);
  endtask

  task automatic push(input int kind);
    ev_t e;
    e.kind = kind; e.bip = c_bip; e.tb = c_tb; e.tt = c_tt; e.m = c_m; e.u = c_u;
    q.push_back(e);
  endtask

  task automatic adv();
    fld++;
    if (fld == 5 + NU) begin
      c_bip = s_bip; c_tb = s_tb; c_tt = s_tt; c_m = s_m; c_u = s_u;
      push(K_OK);
      active = 0;
    end
  endtask

  task automatic check_disp();
    logic [23:0] x;
    x = '1;
    x[23:20] = (fld == 0) ? 4'd1 : 4'(fld);
    if (fld == 1) x[7:0] = {7'd0, s_bip};
    if (fld == 2) x[7:0] = {4'(s_tb / 10), 4'(s_tb % 10)};
    if (fld == 3) x[7:0] = {4'(s_tt / 10), 4'(s_tt % 10)};
    chk("bcd_pac", USR_W'(bcd_pac), USR_W'(x));
    chk("display_en", USR_W'(display_en), USR_W'(1));
  endtask

  task automatic press(input logic [PW_W-1:0] v);
    @(posedge clk); #1;
    key.digitos_value = v;
    key.digitos_valid = 1'b1;
    @(posedge clk); #1;
    key.digitos_valid = 1'b0;
    key.digitos_value = '1;
  endtask

  task automatic enter(input logic [PW_W-1:0] v);
    bit skip, e;
    logic [5:0] r;
    skip = (v == '1);
    if (active) begin
      if (fld == 0) begin
        if (v == c_m) fld = 1;
        else begin
          tries++;
          push(K_ERR);
          if (tries == 3) begin push(K_ABORT); active = 0; end
        end
      end else if (fld == 1) begin
        if (skip) adv();
        else if (v[3:0] < 4'd2) begin s_bip = v[0]; adv(); end
        else push(K_ERR);
      end else if (fld == 2 || fld == 3) begin
        if (!skip) begin
          m_time(v, r, e);
          if (fld == 2) s_tb = r; else s_tt = r;
          if (e) push(K_ERR);
        end
        adv();
      end else begin
        if (skip) adv();
        else if (m_pw_ok(v)) begin
          if (fld == 4) s_m = v; else s_u[(fld-5)*PW_W +: PW_W] = v;
          adv();
        end else push(K_ERR);
      end
    end
    press(v);
    if (active) check_disp();
  endtask

  task automatic start_session();
    @(posedge clk); #1 setup_on = 1'b0;
    repeat (2) @(posedge clk);
    #1 setup_on = 1'b1;
    @(posedge clk); #1;
    active = 1; fld = 0; tries = 0;
    s_bip = c_bip; s_tb = c_tb; s_tt = c_tt; s_m = c_m; s_u = c_u;
    check_disp();
  endtask

  task automatic idle_check();
    repeat (4) @(posedge clk);
    #1;
    chk("idle display_en", USR_W'(display_en), USR_W'(0));
    chk("idle bcd_pac", USR_W'(bcd_pac), USR_W'(24'hFFFFFF));
  endtask

  task automatic drop();
    @(posedge clk); #1 setup_on = 1'b0;
    if (active) begin push(K_ABORT); active = 0; end
    idle_check();
  endtask

  task automatic drop_with_key(input logic [PW_W-1:0] v);
    @(posedge clk); #1;
    setup_on = 1'b0;
    key.digitos_value = v;
    key.digitos_valid = 1'b1;
    if (active) begin push(K_ABORT); active = 0; end
    @(posedge clk); #1;
    key.digitos_valid = 1'b0;
    key.digitos_value = '1;
    idle_check();
  endtask

  function automatic logic [PW_W-1:0] gen(input int f, input bit force_ok);
    int r, d1, d0;
    r = $urandom_range(0, 9);
    if (!force_ok && r < 2) return '1;
    if (f == 1) begin
      if (!force_ok && r < 5) return pw(32'($urandom_range(2, 9)), 1);
      return pw(32'($urandom_range(0, 1)), 1);
    end
    if (f == 2 || f == 3) begin
      d1 = (r < 5) ? 15 : $urandom_range(0, 9);
      if (r == 9) d1 = $urandom_range(10, 14);
      d0 = (r == 8) ? $urandom_range(10, 14) : $urandom_range(0, 9);
      return pw({24'd0, 4'(d1), 4'(d0)}, 2);
    end
    return mk_pw(force_ok ? $urandom_range(4, 8) : $urandom_range(1, 8), !force_ok && r >= 8);
  endfunction

  task automatic rand_session();
    int drop_at, wrong, att, f;
    start_session();
    drop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4 + NU) : -1;
    wrong = $urandom_range(0, 2);
    for (int i = 0; i < wrong; i++) enter(mk_pw($urandom_range(4, 6), 0));
    enter(c_m);
    while (active) begin
      f = fld;
      if (f == drop_at) begin
        if ($urandom_range(0, 1) == 1) drop_with_key(gen(f, 1));
        else drop();
        return;
      end
      att = 0;
      while (active && fld == f) begin
        enter(gen(f, att >= 3));
        att++;
      end
    end
    drop();
  endtask

  // Monitor: every pulse must match the oldest predicted event
  int  mk;
  ev_t me;
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && (data_setup_ok || setup_abort || entry_err)) begin
        mk = (data_setup_ok ? K_OK : 0) + (setup_abort ? K_ABORT : 0) + (entry_err ? K_ERR : 0);
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected pulse: got kind %0d required none", mk);
        end else begin
          me = q.pop_front();
          chk("pulse kind", USR_W'(mk), USR_W'(me.kind));
          chk("cfg_bip_status", USR_W'(cfg_bip_status), USR_W'(me.bip));
          chk("cfg_bip_time", USR_W'(cfg_bip_time), USR_W'(me.tb));
          chk("cfg_trc_time", USR_W'(cfg_trc_time), USR_W'(me.tt));
          chk("cfg_senha_master", USR_W'(cfg_senha_master), USR_W'(me.m));
          chk("cfg_senha_users", cfg_senha_users, me.u);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; setup_on = 1'b0;
    key.digitos_valid = 1'b0; key.digitos_value = '1;
    c_bip = 1'b1; c_tb = 6'd5; c_tt = 6'd5; c_m = pw(32'h1234, 4); c_u = '1;
    active = 0; fld = 0; tries = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst display_en", USR_W'(display_en), USR_W'(0));
    chk("rst bcd_pac", USR_W'(bcd_pac), USR_W'(24'hFFFFFF));
    chk("rst pulses", USR_W'({data_setup_ok, setup_abort, entry_err}), USR_W'(0));
    chk("rst bip", USR_W'(cfg_bip_status), USR_W'(1));
    chk("rst times", USR_W'({cfg_bip_time, cfg_trc_time}), USR_W'({6'd5, 6'd5}));
    chk("rst master", USR_W'(cfg_senha_master), USR_W'({{(PW_W-16){1'b1}}, 16'h1234}));
    chk("rst users", cfg_senha_users, {USR_W{1'b1}});
    rst = 1'b1;

    // Full walk-through with new values
    start_session();
    enter(pw(32'h1234, 4));
    chk("bcd5 F_BIP", USR_W'(bcd_pac[23:20]), USR_W'(1));
    enter(pw(32'h0, 1));
    enter(pw(32'h30, 2));
    enter(pw(32'h45, 2));
    enter(pw(32'h9876, 4));
    enter(pw(32'h1111, 4));
    enter(pw(32'h2222, 4));
    enter(pw(32'h33333, 5));
    enter(pw(32'h444444, 6));
    drop();
    chk("s1 bip", USR_W'(cfg_bip_status), USR_W'(0));
    chk("s1 bip_time", USR_W'(cfg_bip_time), USR_W'(30));
    chk("s1 trc_time", USR_W'(cfg_trc_time), USR_W'(45));
    chk("s1 master", USR_W'(cfg_senha_master), USR_W'(pw(32'h9876, 4)));

    // Three wrong masters abort
    start_session();
    repeat (3) enter(pw(32'h1111, 4));
    drop();
    chk("s2 bip_time kept", USR_W'(cfg_bip_time), USR_W'(30));
    chk("s2 master kept", USR_W'(cfg_senha_master), USR_W'(pw(32'h9876, 4)));

    // Out-of-range time, skips, short user password
    start_session();
    enter(pw(32'h9876, 4));
    enter('1);
    enter(pw(32'h75, 2));
    enter('1);
    enter('1);
    enter(pw(32'h12, 2));
    chk("short pw stays", USR_W'(bcd_pac[23:20]), USR_W'(5));
    enter(pw(32'h1234, 4));
    chk("user0 advances", USR_W'(bcd_pac[23:20]), USR_W'(6));
    repeat (3) enter('1);
    drop();
    chk("s3 bip kept", USR_W'(cfg_bip_status), USR_W'(0));
    chk("s3 bip_time default", USR_W'(cfg_bip_time), USR_W'(5));
    chk("s3 trc kept", USR_W'(cfg_trc_time), USR_W'(45));
    chk("s3 user0", USR_W'(cfg_senha_users[PW_W-1:0]), USR_W'(pw(32'h1234, 4)));
    chk("s3 user1 kept", USR_W'(cfg_senha_users[2*PW_W-1:PW_W]), USR_W'(pw(32'h2222, 4)));

    // Single-digit time and upper boundary
    start_session();
    enter(pw(32'h9876, 4));
    enter(pw(32'h1, 1));
    enter(pw(32'h5, 1));
    enter(pw(32'h60, 2));
    repeat (1 + NU) enter('1);
    drop();
    chk("s4 trc 60", USR_W'(cfg_trc_time), USR_W'(60));
    chk("s4 bip 1", USR_W'(cfg_bip_status), USR_W'(1));

    // Drop during master entry
    start_session();
    enter(pw(32'h9876, 4));
    repeat (3) enter('1);
    drop();
    chk("s5 trc kept", USR_W'(cfg_trc_time), USR_W'(60));
    chk("s5 master kept", USR_W'(cfg_senha_master), USR_W'(pw(32'h9876, 4)));

    for (int s = 0; s < 14; s++) rand_session();

    // Inactivity in F_BIP
    start_session();
    enter(c_m);
`ifdef SETUP_TIMEOUT_EN
    push(K_ABORT);
    active = 0;
    repeat (150) @(posedge clk);
    #1 chk("timeout display_en", USR_W'(display_en), USR_W'(0));
`else
    repeat (150) @(posedge clk);
    #1 chk("no timeout bcd5", USR_W'(bcd_pac[23:20]), USR_W'(1));
    chk("no timeout display_en", USR_W'(display_en), USR_W'(1));
`endif
    drop();

    // Reset in the middle of a session
    start_session();
    enter(c_m);
    @(posedge clk); #1;
    rst = 1'b0; setup_on = 1'b0;
    @(posedge clk); #1;
    active = 0;
    c_bip = 1'b1; c_tb = 6'd5; c_tt = 6'd5; c_m = pw(32'h1234, 4); c_u = '1;
    chk("midrst display_en", USR_W'(display_en), USR_W'(0));
    chk("midrst master", USR_W'(cfg_senha_master), USR_W'(c_m));
    chk("midrst bip_time", USR_W'(cfg_bip_time), USR_W'(5));
    rst = 1'b1;

    repeat (10) @(posedge clk);
    #1 chk("events drained", USR_W'(q.size()), USR_W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
